// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: drives an external up/down counter through repeated
// lo -> hi -> lo sweeps, with optional hold time at each bound. The counter
// value is observed on count_in; the controller steers it with cnt_rst,
// cnt_enable and cnt_direction, which depend on the state register only.
//
// Control protocol: start is a level sampled only in IDLE; a start seen with
// stop low and lo_limit < hi_limit is accepted on that edge, a start with
// lo_limit >= hi_limit is rejected with a one-cycle cfg_err pulse. stop is
// sampled every cycle and returns any active run to IDLE on the next edge.
module counter_sweep_ctrl #(
  parameter int WIDTH      = 8,
  parameter int MAX_SWEEPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] lo_limit,
  input  logic [WIDTH-1:0] hi_limit,
  input  logic [3:0]       dwell,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_rst,
  output logic             cnt_enable,
  output logic             cnt_direction,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [7:0]       sweep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_PRELOAD  = 3'd2,
    S_UP       = 3'd3,
    S_DWELL_HI = 3'd4,
    S_DOWN     = 3'd5,
    S_DWELL_LO = 3'd6,
    S_DONE     = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [3:0]       dwell_cfg_q, dwell_cfg_d;
  logic [3:0]       dwell_cnt_q, dwell_cnt_d;
  logic [7:0]       sweep_cnt_q, sweep_cnt_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;

  // Bound-approach thresholds: the counter moves one step per enabled edge,
  // so the state changes on the edge where it is one step short of a bound.
  logic [WIDTH-1:0] lo_m1;
  logic [WIDTH-1:0] lo_p1;
  logic [WIDTH-1:0] hi_m1;
  logic [7:0]       sweep_next;

  assign lo_m1      = lo_q - WIDTH'(1);
  assign lo_p1      = lo_q + WIDTH'(1);
  assign hi_m1      = hi_q - WIDTH'(1);
  assign sweep_next = sweep_cnt_q + 8'd1;

  // Next-state and datapath update; stop overrides every other transition.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    dwell_cfg_d = dwell_cfg_q;
    dwell_cnt_d = dwell_cnt_q;
    sweep_cnt_d = sweep_cnt_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (lo_limit < hi_limit) begin
            lo_d        = lo_limit;
            hi_d        = hi_limit;
            dwell_cfg_d = dwell;
            sweep_cnt_d = 8'd0;
            state_d     = S_CLEAR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        state_d = (lo_q == '0) ? S_UP : S_PRELOAD;
      end
      S_PRELOAD: begin
        if (count_in == lo_m1) state_d = S_UP;
      end
      S_UP: begin
        if (count_in == hi_m1) begin
          state_d     = S_DWELL_HI;
          dwell_cnt_d = dwell_cfg_q;
        end
      end
      S_DWELL_HI: begin
        if (dwell_cnt_q == 4'd0) state_d = S_DOWN;
        else                     dwell_cnt_d = dwell_cnt_q - 4'd1;
      end
      S_DOWN: begin
        if (count_in == lo_p1) begin
          state_d     = S_DWELL_LO;
          dwell_cnt_d = dwell_cfg_q;
        end
      end
      S_DWELL_LO: begin
        if (dwell_cnt_q == 4'd0) begin
          sweep_cnt_d = sweep_next;
          if (sweep_next == 8'(MAX_SWEEPS)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_UP;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (stop && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      done_d      = 1'b0;
      dwell_cnt_d = dwell_cnt_q;
      sweep_cnt_d = sweep_cnt_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      dwell_cfg_q <= 4'd0;
      dwell_cnt_q <= 4'd0;
      sweep_cnt_q <= 8'd0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      dwell_cfg_q <= dwell_cfg_d;
      dwell_cnt_q <= dwell_cnt_d;
      sweep_cnt_q <= sweep_cnt_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Counter controls are a pure decode of the state register.
  assign cnt_rst       = (state_q == S_CLEAR);
  assign cnt_enable    = (state_q == S_PRELOAD) || (state_q == S_UP) ||
                         (state_q == S_DOWN);
  assign cnt_direction = (state_q == S_PRELOAD) || (state_q == S_UP);
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;
  assign sweep_cnt     = sweep_cnt_q;

endmodule

// File: doc/counter_sweep_ctrl.md
COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: width of counter value and limit ports.
REQ-002 Parameter MAX_SWEEPS, default 4: full up/down sweeps per run, range 1-255.
REQ-003 Port clk, input, 1: the only clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: begin a run; sampled in IDLE only.
REQ-006 Port stop, input, 1: abort the run; sampled in every state.
REQ-007 Port lo_limit, input, WIDTH: sweep lower bound.
REQ-008 Port hi_limit, input, WIDTH: sweep upper bound.
REQ-009 Port dwell, input, 4: extra hold cycles at each bound.
REQ-010 Port count_in, input, WIDTH: current value of the controlled up/down counter.
REQ-011 Port cnt_rst, output, 1: reset request to the counter.
REQ-012 Port cnt_enable, output, 1: counter enable.
REQ-013 Port cnt_direction, output, 1: 1 = count up, 0 = count down.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port done, output, 1: one-cycle pulse at normal run completion.
REQ-016 Port cfg_err, output, 1: one-cycle pulse on a rejected start.
REQ-017 Port sweep_cnt, output, 8: sweeps completed in the current or last run.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, PRELOAD, UP, DWELL_HI, DOWN, DWELL_LO, DONE.
REQ-019 cnt_rst, cnt_enable and cnt_direction SHALL be decoded from the state register only, with no input-to-output combinational path.
REQ-020 Decode SHALL be: CLEAR gives cnt_rst=1; PRELOAD and UP give enable=1, direction=1; DOWN gives enable=1, direction=0; all other states give all three outputs 0.
REQ-021 In IDLE, start=1 with stop=0 and lo_limit<hi_limit SHALL register both limits and dwell, clear sweep_cnt, and go to CLEAR.
REQ-022 In IDLE, start=1 with lo_limit>=hi_limit SHALL stay in IDLE and pulse cfg_err for one cycle.
REQ-023 CLEAR SHALL last 1 cycle, then go to UP if registered lo=0, else to PRELOAD.
REQ-024 PRELOAD SHALL go to UP on the edge where count_in==lo-1; the counter then lands on lo.
REQ-025 UP SHALL go to DWELL_HI on the edge where count_in==hi-1; the counter lands on hi.
REQ-026 DOWN SHALL go to DWELL_LO on the edge where count_in==lo+1; the counter lands on lo.
REQ-027 Each DWELL state SHALL last dwell+1 cycles, timed by a 4-bit counter reloaded on state entry.
REQ-028 DWELL_HI SHALL then go to DOWN.
REQ-029 On leaving DWELL_LO, sweep_cnt SHALL increment; the FSM goes to DONE if the new value equals MAX_SWEEPS, else to UP.
REQ-030 DONE SHALL last 1 cycle with done=1, then go to IDLE; sweep_cnt holds until the next accepted start.
REQ-031 stop=1 in any non-IDLE state SHALL go to IDLE on the next edge with no done pulse; the counter holds its value.
REQ-032 stop SHALL take priority over every other transition, including a simultaneous start or limit match.
REQ-033 start while busy SHALL be ignored; limit port changes during a run SHALL have no effect.
REQ-034 Limit comparisons SHALL be exact WIDTH-bit equality; the controller never drives the counter past a bound, so no wrap occurs.

Reset
REQ-035 rst=1 SHALL force IDLE and clear sweep_cnt, done, cfg_err, dwell counter and registered config, giving cnt_rst=cnt_enable=cnt_direction=busy=0.
REQ-036 rst SHALL override start and stop, and SHALL abort any run in progress within one cycle.

Verification
REQ-037 Normal run, lo=2, hi=5, dwell=0, MAX_SWEEPS=2, start pulse -> count_in per edge after CLEAR is 0,1,2,3,4,5,5,4,3,2,2,3,4,5,5,4,3,2,2; done pulses once; sweep_cnt=2; busy falls after DONE.
REQ-038 lo=0, hi=3, dwell=2 -> PRELOAD skipped; counter holds 3 for 3 cycles and 0 for 3 cycles.
REQ-039 start with lo=7, hi=7, then lo=9, hi=4 -> cfg_err pulses each time; busy stays 0; count_in unchanged.
REQ-040 stop asserted in DOWN at count 4 -> IDLE next cycle; count_in frozen at 3 or 4 per decode timing; no done pulse; sweep_cnt unchanged.
REQ-041 rst mid-DWELL_HI, start in the same cycle as stop, and start while busy -> IDLE with outputs 0; no run starts; the current run is unaffected.
REQ-042 hi=lo+1 (lo=10, hi=11) -> single-step ramps; counter alternates 10 and 11 with one-cycle holds; MAX_SWEEPS honoured.
